// File: rtl/tcp_window_rewriter.sv
// Rewrites the TCP receive window of IPv4/TCP packets on the 64-bit user datapath and
// patches the TCP checksum incrementally (RFC 1624). Registers and counters sit on the register ring.
module tcp_window_rewriter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_SRC_PORTS = 8,
  parameter logic [7:0] IOQ_CTRL = 8'hFF,
  parameter int REG_ADDR_WIDTH = 23,
  parameter logic [REG_ADDR_WIDTH-1:0] REG_BASE_ADDR = 23'h000100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_l_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_l_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  output logic [3:0]                   fsm_state
);

  localparam int FW = DATA_WIDTH + CTRL_WIDTH;
  localparam int PW = (NUM_SRC_PORTS > 1) ? $clog2(NUM_SRC_PORTS) : 1;

  // Handshake: a word moves downstream on every cycle where the FIFO is non-empty and
  // out_rdy is high; it appears on out_* with out_wr=1 one clock later.
  typedef enum logic [3:0] {
    HDR    = 4'b0001,
    PARSE  = 4'b0010,
    MODIFY = 4'b0100,
    PASS   = 4'b1000
  } state_t;

  state_t state;
  logic [3:0] w;
  logic [3:0] ihl_q;
  logic [15:0] src_port;
  logic [31:0] cnt0, cnt1;

  logic [15:0] win_cfg;
  logic en, mode;
  logic [NUM_SRC_PORTS-1:0] port_mask;

  // ---------------- input FIFO (fallthrough, depth 4) ----------------
  logic [FW-1:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_count;
  logic push, pop, empty;

  assign empty  = (fifo_count == 3'd0);
  assign in_rdy = (fifo_count < 3'd3);
  assign push   = in_wr && (fifo_count != 3'd4);
  assign pop    = !empty && out_rdy;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b0, push} - {2'b0, pop};
    end
  end

  logic [DATA_WIDTH-1:0] cur_data;
  logic [CTRL_WIDTH-1:0] cur_ctrl;
  assign {cur_ctrl, cur_data} = fifo_mem[rd_ptr];

  // ---------------- header checks and window rewrite ----------------
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s, t;
    s = {1'b0, a} + {1'b0, b};
    t = {1'b0, s[15:0]} + {16'b0, s[16]};
    return t[15:0] + {15'b0, t[16]};
  endfunction

  logic eth_ok, tcp_ok, port_ok, win_changed, lane_hi;
  logic [6:0] win_bytes;
  logic [3:0] win_last;
  logic [15:0] old_win, old_csum, new_win, new_csum;
  logic [DATA_WIDTH-1:0] mod_data;

  always_comb begin
    eth_ok    = (cur_data[31:16] == 16'h0800) && (cur_data[15:12] == 4'd4) && (cur_data[11:8] >= 4'd5);
    tcp_ok    = (cur_data[7:0] == 8'h06) && (cur_data[28:16] == 13'd0);
    port_ok   = (src_port < 16'(NUM_SRC_PORTS)) && port_mask[src_port[PW-1:0]];
    win_bytes = 7'd28 + {1'b0, ihl_q, 2'b00};
    win_last  = win_bytes[6:3] - 4'd1;
    // Odd IHL puts the window in the upper half of the word, even IHL in the lower half.
    lane_hi   = ihl_q[0];
    old_win   = lane_hi ? cur_data[63:48] : cur_data[31:16];
    old_csum  = lane_hi ? cur_data[47:32] : cur_data[15:0];
    new_win   = mode ? ((old_win < win_cfg) ? old_win : win_cfg) : win_cfg;
    new_csum  = ~oc_add(oc_add(~old_csum, ~old_win), new_win);
    win_changed = (new_win != old_win);
    mod_data  = cur_data;
    if (win_changed) begin
      if (lane_hi) mod_data[63:32] = {new_win, new_csum};
      else         mod_data[31:0]  = {new_win, new_csum};
    end
  end

  // ---------------- packet state machine and output register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR;
      w        <= '0;
      ihl_q    <= '0;
      src_port <= '0;
      cnt0     <= '0;
      cnt1     <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_ctrl <= cur_ctrl;
        out_data <= (state == MODIFY) ? mod_data : cur_data;
        unique case (state)
          HDR: begin
            if (cur_ctrl == CTRL_WIDTH'(IOQ_CTRL)) begin
              src_port <= cur_data[47:32];
            end else if (cur_ctrl == '0) begin
              state <= PARSE;
              w     <= 4'd1;
            end
          end
          PARSE: begin
            if (w == 4'd1) ihl_q <= cur_data[11:8];
            if (cur_ctrl != '0) begin
              state <= HDR;
              w     <= '0;
            end else if (w == 4'd1 && !eth_ok) begin
              state <= PASS;
              w     <= '0;
            end else if (w == 4'd2 && !tcp_ok) begin
              state <= PASS;
              w     <= '0;
            end else if (w == 4'd2 && !(en && port_ok)) begin
              // Valid IPv4/TCP but disabled for this source: counted as passed unchanged.
              state <= PASS;
              w     <= '0;
              cnt1  <= cnt1 + 32'd1;
            end else if (w == win_last) begin
              state <= MODIFY;
            end else begin
              w <= w + 4'd1;
            end
          end
          MODIFY: begin
            if (win_changed) cnt0 <= cnt0 + 32'd1;
            else             cnt1 <= cnt1 + 32'd1;
            state <= (cur_ctrl != '0) ? HDR : PASS;
            w     <= '0;
          end
          PASS: begin
            if (cur_ctrl != '0) state <= HDR;
          end
          default: begin
            state <= HDR;
            w     <= '0;
          end
        endcase
      end
    end
  end

  assign fsm_state = state;

  // ---------------- register ring ----------------
  logic reg_hit;
  logic [31:0] reg_rd_val;

  assign reg_hit = reg_req_in && !reg_ack_in &&
                   (reg_addr_in[REG_ADDR_WIDTH-1:2] == REG_BASE_ADDR[REG_ADDR_WIDTH-1:2]);

  always_comb begin
    reg_rd_val = '0;
    case (reg_addr_in[1:0])
      2'd0: reg_rd_val = {16'h0, win_cfg};
      2'd1: reg_rd_val = 32'({port_mask, 6'b0, mode, en});
      2'd2: reg_rd_val = cnt0;
      default: reg_rd_val = cnt1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_l_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      win_cfg         <= '0;
      en              <= 1'b0;
      mode            <= 1'b0;
      port_mask       <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_l_out <= reg_rd_wr_l_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      if (reg_hit) begin
        reg_ack_out  <= 1'b1;
        reg_data_out <= reg_rd_wr_l_in ? reg_rd_val : reg_data_in;
        if (!reg_rd_wr_l_in) begin
          case (reg_addr_in[1:0])
            2'd0: win_cfg <= reg_data_in[15:0];
            2'd1: begin
              en        <= reg_data_in[0];
              mode      <= reg_data_in[1];
              port_mask <= reg_data_in[8+NUM_SRC_PORTS-1:8];
            end
            default: ;
          endcase
        end
      end else begin
        reg_ack_out  <= reg_ack_in;
        reg_data_out <= reg_data_in;
      end
    end
  end

endmodule

// File: tb/tb_tcp_window_rewriter.sv
// Directed bench for tcp_window_rewriter: vector table of packets with hand-computed
// window/checksum results, plus back-pressure and mid-packet reset sequences.
module tb_tcp_window_rewriter;

  localparam logic [22:0] BASE = 23'h000100;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_l_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_l_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;
  logic [3:0]  fsm_state;

  tcp_window_rewriter dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_l_in(reg_rd_wr_l_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_l_out(reg_rd_wr_l_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] ethertype;
    logic [7:0]  ver_ihl;
    logic [7:0]  proto;
    logic [15:0] frag;
    logic [15:0] src_port;
    logic [15:0] win_in;
    logic [15:0] csum_in;
    logic [15:0] sw_win;
    logic        mode;
    logic        en;
    logic [7:0]  mask;
    int          nwords;
    int          win_word;
    logic        lane_hi;
    logic        modify;
    logic [15:0] exp_win;
    logic [15:0] exp_csum;
    int          cnt0_inc;
    int          cnt1_inc;
  } vec_t;

  vec_t vecs[15];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [71:0] exp_q[$];
  logic [71:0] tx_q[$];
  bit   mon_on = 1'b1;
  bit   bp_on  = 1'b0;
  bit   saw_full = 1'b0;
  logic rdy_at_edge = 1'b0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) rdy_at_edge = out_rdy;

  always @(negedge clk) begin
    logic [71:0] e;
    if (bp_on && !in_rdy) saw_full = 1'b1;
    if (out_wr && mon_on) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_word: got %h, expected no word", {out_ctrl, out_data});
      end else begin
        e = exp_q.pop_front();
        check("out_word", {out_ctrl, out_data}, e);
      end
      check("wr_needs_rdy", 72'(rdy_at_edge), 72'd1);
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_word(input logic [71:0] wd);
    int g = 0;
    while (!in_rdy && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (!in_rdy) begin
      chk_cnt++;
      $display("FAIL in_rdy_timeout: got in_rdy 0, expected 1 within 200 cycles");
    end
    {in_ctrl, in_data} = wd;
    in_wr = 1'b1;
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic send_all();
    logic [71:0] wd;
    while (tx_q.size() > 0) begin
      wd = tx_q.pop_front();
      push_word(wd);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk); #1; g++;
    end
    check("drain_remaining", 72'(exp_q.size()), 72'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reg_access(input logic rd, input logic [1:0] off, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    int g = 0;
    reg_req_in = 1'b1; reg_rd_wr_l_in = rd; reg_addr_in = {BASE[22:2], off};
    reg_data_in = wdata; reg_ack_in = 1'b0; reg_src_in = 2'd0;
    @(posedge clk); #1;
    reg_req_in = 1'b0; reg_rd_wr_l_in = 1'b0; reg_addr_in = '0; reg_data_in = '0;
    while (!(reg_req_out && reg_ack_out) && g < 20) begin
      @(posedge clk); #1; g++;
    end
    if (!(reg_req_out && reg_ack_out)) begin
      chk_cnt++;
      $display("FAIL reg_ack_timeout: got no ack, expected ack within 20 cycles");
    end
    rdata = reg_data_out;
  endtask

  task automatic cfg(input logic [15:0] win, input logic md, input logic e, input logic [7:0] mask);
    logic [31:0] d;
    reg_access(1'b0, 2'd0, {16'h0, win}, d);
    reg_access(1'b0, 2'd1, {16'h0, mask, 6'b0, md, e}, d);
  endtask

  task automatic check_cnts(input int e0, input int e1);
    logic [31:0] d;
    reg_access(1'b1, 2'd2, 32'h0, d);
    check("cnt0", 72'(d), 72'(e0));
    reg_access(1'b1, 2'd3, 32'h0, d);
    check("cnt1", 72'(d), 72'(e1));
  endtask

  // Builds one packet into tx_q and its expected output into exp_q.
  task automatic make_pkt(input vec_t v);
    logic [63:0] d;
    logic [71:0] e;
    logic [71:0] words[$];
    d = {$urandom(), $urandom()};
    d[47:32] = v.src_port;
    words.push_back({8'hFF, d});
    for (int i = 0; i < v.nwords; i++) begin
      d = {$urandom(), $urandom()};
      if (i == 1) begin d[31:16] = v.ethertype; d[15:8] = v.ver_ihl; end
      if (i == 2) begin d[31:16] = v.frag; d[7:0] = v.proto; end
      if (i == v.win_word) begin
        if (v.lane_hi) d[63:32] = {v.win_in, v.csum_in};
        else           d[31:0]  = {v.win_in, v.csum_in};
      end
      words.push_back({(i == v.nwords - 1) ? 8'h02 : 8'h00, d});
    end
    foreach (words[k]) begin
      e = words[k];
      if (v.modify && k == v.win_word + 1) begin
        if (v.lane_hi) e[63:32] = {v.exp_win, v.exp_csum};
        else           e[31:0]  = {v.exp_win, v.exp_csum};
      end
      exp_q.push_back(e);
      tx_q.push_back(words[k]);
    end
  endtask

  function automatic vec_t mk(string nm, logic [15:0] et, logic [7:0] vi, logic [7:0] pr,
                              logic [15:0] fr, logic [15:0] sp, logic [15:0] wi, logic [15:0] cs,
                              logic [15:0] sw, logic md, logic e, logic [7:0] msk, int nw, int ww,
                              logic hi, logic mo, logic [15:0] ew, logic [15:0] ec, int c0, int c1);
    vec_t v;
    v.name = nm; v.ethertype = et; v.ver_ihl = vi; v.proto = pr; v.frag = fr; v.src_port = sp;
    v.win_in = wi; v.csum_in = cs; v.sw_win = sw; v.mode = md; v.en = e; v.mask = msk;
    v.nwords = nw; v.win_word = ww; v.lane_hi = hi; v.modify = mo; v.exp_win = ew;
    v.exp_csum = ec; v.cnt0_inc = c0; v.cnt1_inc = c1;
    return v;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int exp0, exp1;
    vec_t v;
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_l_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;

    vecs[0]  = mk("overwrite",  16'h0800, 8'h45, 8'h06, 16'h4000, 16'd0, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b1, 16'h0400, 16'h0E34, 1, 0);
    vecs[1]  = mk("clamp_keep", 16'h0800, 8'h45, 8'h06, 16'h0000, 16'd1, 16'h0200, 16'h5555, 16'h0400, 1'b1, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1);
    vecs[2]  = mk("clamp_cut",  16'h0800, 8'h45, 8'h06, 16'h0000, 16'd2, 16'h8000, 16'h1234, 16'h0400, 1'b1, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b1, 16'h0400, 16'h8E34, 1, 0);
    vecs[3]  = mk("ihl6",       16'h0800, 8'h46, 8'h06, 16'h0000, 16'd0, 16'h1000, 16'hABCD, 16'h0800, 1'b0, 1'b1, 8'hFF, 10, 6, 1'b0, 1'b1, 16'h0800, 16'hB3CD, 1, 0);
    vecs[4]  = mk("ihl7",       16'h0800, 8'h47, 8'h06, 16'h0000, 16'd0, 16'h1000, 16'hABCD, 16'h0800, 1'b0, 1'b1, 8'hFF, 10, 7, 1'b1, 1'b1, 16'h0800, 16'hB3CD, 1, 0);
    vecs[5]  = mk("ipv6",       16'h86DD, 8'h45, 8'h06, 16'h0000, 16'd0, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 0);
    vecs[6]  = mk("udp",        16'h0800, 8'h45, 8'h11, 16'h0000, 16'd0, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 0);
    vecs[7]  = mk("frag",       16'h0800, 8'h45, 8'h06, 16'h0010, 16'd0, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 0);
    vecs[8]  = mk("mask_off",   16'h0800, 8'h45, 8'h06, 16'h0000, 16'd3, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hF7, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1);
    vecs[9]  = mk("en_off",     16'h0800, 8'h45, 8'h06, 16'h0000, 16'd0, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b0, 8'hFF, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1);
    vecs[10] = mk("port_oob",   16'h0800, 8'h45, 8'h06, 16'h0000, 16'd9, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1);
    vecs[11] = mk("same_win",   16'h0800, 8'h45, 8'h06, 16'h0000, 16'd0, 16'h0400, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hFF, 10, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1);
    vecs[12] = mk("ihl15",      16'h0800, 8'h4F, 8'h06, 16'h0000, 16'd0, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 8'hFF, 14, 11, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1, 0);
    vecs[13] = mk("short",      16'h0800, 8'h45, 8'h06, 16'h0000, 16'd0, 16'hFFFF, 16'h1234, 16'h0400, 1'b0, 1'b1, 8'hFF, 6, 6, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 0);
    vecs[14] = mk("eop_win",    16'h0800, 8'h45, 8'h06, 16'h0000, 16'd0, 16'h2000, 16'h0000, 16'h0400, 1'b0, 1'b1, 8'hFF, 7, 6, 1'b1, 1'b1, 16'h0400, 16'h1C00, 1, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wr", 72'(out_wr), 72'd0);
    check("rst_out_data", 72'(out_data), 72'd0);
    check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    check("rst_state", 72'(fsm_state), 72'h1);
    check("rst_in_rdy", 72'(in_rdy), 72'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_cnts(0, 0);

    // Vector table
    exp0 = 0; exp1 = 0;
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      cfg(v.sw_win, v.mode, v.en, v.mask);
      make_pkt(v);
      send_all();
      wait_drain();
      exp0 += v.cnt0_inc;
      exp1 += v.cnt1_inc;
      check_cnts(exp0, exp1);
    end

    // Back-pressure: three back-to-back 10-word packets with random out_rdy
    v = vecs[0];
    v.nwords = 9;
    cfg(v.sw_win, v.mode, v.en, v.mask);
    bp_on = 1'b1;
    for (int p = 0; p < 3; p++) make_pkt(v);
    send_all();
    wait_drain();
    bp_on = 1'b0;
    check("in_rdy_dropped", 72'(saw_full), 72'd1);
    exp0 += 3;
    check_cnts(exp0, exp1);

    // Reset at packet word 4
    v = vecs[0];
    mon_on = 1'b0;
    make_pkt(v);
    for (int k = 0; k < 5; k++) begin
      logic [71:0] wd;
      wd = tx_q.pop_front();
      push_word(wd);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_out_wr", 72'(out_wr), 72'd0);
    check("rst_mid_state", 72'(fsm_state), 72'h1);
    check("rst_mid_in_rdy", 72'(in_rdy), 72'd1);
    tx_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_mid_no_wr", 72'(out_wr), 72'd0);
    mon_on = 1'b1;
    check_cnts(0, 0);
    cfg(v.sw_win, v.mode, v.en, v.mask);
    make_pkt(v);
    send_all();
    wait_drain();
    check_cnts(1, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
